dmem_responder: RTL and testbench

Handshaked data-memory responder for the MIPS data bus: accepts one load/store request at a time, holds it for a programmable number of wait states, then returns a single-cycle response. It sits between the processor's memory port and a word-addressed RAM. It replaces the zero-latency data memory when bench or system timing needs realistic memory latency and back-pressure.

---
 rtl/dmem_pkg.sv | 6 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;
endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with write-enable and a registered, write-first read port.
module dmem_array #(
  parameter int WORDS = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  import dmem_pkg::*;

  logic [WORD_W-1:0] mem_q [WORDS];
  logic [WORD_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (en && we) mem_q[idx] <= wdata;
  end

  // A store returns the word it writes, so the read register takes wdata directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rd_q <= '0;
    else if (en) rd_q <= we ? wdata : mem_q[idx];
  end

  assign rdata = rd_q;
endmodule

// File: rtl/dmem_responder.sv
// Handshaked MIPS data-memory responder: one request at a time, WAIT wait states, one-cycle response.
// Optional misaligned-access check enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int WORDS = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);
  import dmem_pkg::*;

  localparam int IDX_W = $clog2(WORDS);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              commit;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              cur_we;
  logic [IDX_W-1:0]  cur_idx;
  logic [WORD_W-1:0] cur_wdata;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr;

  assign unused_addr = ^addr;

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      we_q    <= we;
      idx_q   <= addr[IDX_W+1:2];
      wdata_q <= wdata;
    end
  end

  // With WAIT=0 the commit edge is the acceptance edge, so the live request is used.
  always_comb begin
    cur_we    = we_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_we    = we;
      cur_idx   = addr[IDX_W+1:2];
      cur_wdata = wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = dmem_pkg::WAIT;
            cnt_d   = CNT_W'(WAIT);
          end
        end
      end
      dmem_pkg::WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign rvalid = (state_q == RESP);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic mis_q, cur_mis, zero_q;

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) mis_q <= (addr[1:0] != 2'b00);
  end

  assign cur_mis = (state_q == IDLE) ? (addr[1:0] != 2'b00) : mis_q;

  // zero_q forces rdata to 0 after a misaligned commit and holds until the next commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      zero_q <= 1'b0;
    else if (commit) zero_q <= cur_mis;
  end

  assign ram_we = cur_we & ~cur_mis;
  assign rdata  = zero_q ? '0 : ram_rdata;
  assign err    = rvalid & zero_q;
`else
  assign ram_we = cur_we;
  assign rdata  = ram_rdata;
  assign err    = 1'b0;
`endif

  dmem_array #(.WORDS(WORDS)) u_array (
    .clk   (clk),
    .rst_n (reset),
    .en    (commit),
    .we    (ram_we),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, multi-cycle corner sequences, random vs. model.
module tb_dmem_responder;
  localparam int WORDS = 64;
  localparam int WAITN = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, rvalid, err;
  logic [31:0] rdata;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  dmem_responder #(.WORDS(WORDS), .WAIT(WAITN)) u2 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  dmem_responder #(.WORDS(WORDS), .WAIT(0)) u0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] model_mem [WORDS];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'((a / 32'd4) % WORDS);
  endfunction

  function automatic logic misal(input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    return (a % 32'd4) != 32'd0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour of one complete transaction.
  task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] er, output logic ee);
    if (misal(a)) begin
      er = '0;
      ee = 1'b1;
    end else if (w) begin
      model_mem[midx(a)] = d;
      er = d;
      ee = 1'b0;
    end else begin
      er = model_mem[midx(a)];
      ee = 1'b0;
    end
  endtask

  // Issue one request on u2 starting at a negedge; returns response and timing.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat, output int early);
    int n;
    req = 1'b1; we = w; addr = a; wdata = d;
    n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    if (!ready) check_bit("accept_timeout", ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
    lat = 1; early = 0;
    while (!rvalid && lat < 40) begin
      early += int'(ready);
      @(negedge clk);
      lat++;
    end
    rd = rdata;
    e  = err;
    check_bit("resp_ready_low", ready, 1'b0);
    @(negedge clk);
    check_bit("rvalid_single", rvalid, 1'b0);
  endtask

  task automatic run_and_check(input string name, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] er, rd;
    logic ee, e;
    int lat, early;
    model_txn(w, a, d, er, ee);
    txn(w, a, d, rd, e, lat, early);
    check({name, "_rdata"}, rd, er);
    check_bit({name, "_err"}, e, ee);
    check_int({name, "_latency"}, lat, WAITN + 1);
    check_int({name, "_ready_in_wait"}, early, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    logic [31:0] cap, er, rd, a;
    logic ee, e;
    int lat, early;

    for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
    vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0104, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_000C, 32'h0000_0000, 32'h0000_0000, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check_bit("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check_bit("rst_err", err, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_bit("rst_ready", ready, 1'b1);
    check_bit("rst_ready0", ready0, 1'b1);

    // Reset in the middle of a store's wait states drops it
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); pulses += int'(rvalid); end
    check("midrst_rdata", rdata, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); pulses += int'(rvalid); end
    check_int("midrst_no_rvalid", pulses, 0);
    run_and_check("midrst_reload", 1'b0, 32'h10, 32'h0);

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      model_txn(vecs[i].w, vecs[i].a, vecs[i].d, er, ee);
      txn(vecs[i].w, vecs[i].a, vecs[i].d, rd, e, lat, early);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check_bit($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      check_int($sformatf("vec%0d_latency", i), lat, WAITN + 1);
    end

    // Request while busy is ignored
    model_txn(1'b1, 32'h20, 32'h0BAD_F00D, er, ee);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0BAD_F00D;
    @(posedge clk);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h7777_7777;
    @(negedge clk);
    req = 1'b0;
    pulses = 0; cap = '0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid) begin pulses++; cap = rdata; end
      @(negedge clk);
    end
    check_int("ignored_pulses", pulses, 1);
    check("ignored_rdata", cap, 32'h0BAD_F00D);
    run_and_check("ignored_q_untouched", 1'b0, 32'h30, 32'h0);
    run_and_check("ignored_p_load", 1'b0, 32'h20, 32'h0);

    // WAIT=0 back-to-back with req held high
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h1;
    check_bit("w0_ready_a", ready0, 1'b1);
    @(negedge clk);
    check_bit("w0_rvalid_a", rvalid0, 1'b1);
    check_bit("w0_ready_resp_a", ready0, 1'b0);
    check("w0_store_rdata", rdata0, 32'h1);
    we0 = 1'b0; wdata0 = 32'hFFFF_FFFF;
    @(negedge clk);
    check_bit("w0_rvalid_gap", rvalid0, 1'b0);
    check_bit("w0_ready_b", ready0, 1'b1);
    @(negedge clk);
    req0 = 1'b0;
    check_bit("w0_rvalid_b", rvalid0, 1'b1);
    check_bit("w0_ready_resp_b", ready0, 1'b0);
    check("w0_load_rdata", rdata0, 32'h1);
    check_bit("w0_err", err0, 1'b0);
    @(negedge clk);
    check_bit("w0_rvalid_end", rvalid0, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
    // Misaligned store is suppressed and flagged
    txn(1'b1, 32'h0A, 32'hFFFF_FFFF, rd, e, lat, early);
    check("mis_store_rdata", rd, 32'h0);
    check_bit("mis_store_err", e, 1'b1);
    txn(1'b0, 32'h08, 32'h0, rd, e, lat, early);
    check("mis_load_rdata", rd, 32'hDEAD_BEEF);
    check_bit("mis_load_err", e, 1'b0);
`endif

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 2) == 0) a[31:8] = '0;
      run_and_check($sformatf("rnd%0d", i), 1'($urandom), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
